axi4_sram_slave: RTL

AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

---
 rtl/axi4_sram_slave.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by an on-chip word array; write and read channels are independent single-burst FSMs.
// Optional WRAP burst support is enabled with `define AXI4_SRAM_WRAP_BURST_EN.
module axi4_sram_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    // state  | meaning
    // W_IDLE | waiting for AW          R_IDLE | waiting for AR
    // W_DATA | accepting W beats       R_WAIT | read latency countdown
    // W_RESP | presenting B response   R_DATA | presenting R beats
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (SHIFT + IDX_W)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[SHIFT +: IDX_W];
    endfunction

    // mask selects the address bits allowed to change; all ones gives plain INCR
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic fixed,
                                                        input logic [ADDR_WIDTH-1:0] mask);
        logic [ADDR_WIDTH-1:0] inc;
        inc = a + ADDR_WIDTH'(BYTES);
        return fixed ? a : ((a & ~mask) | (inc & mask));
    endfunction

`ifdef AXI4_SRAM_WRAP_BURST_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

    logic aw_fixed, aw_slverr, ar_fixed, ar_slverr;
    logic [ADDR_WIDTH-1:0] aw_mask, ar_mask;

    always_comb begin
        aw_fixed  = s_axi_awburst == 2'b00;
        ar_fixed  = s_axi_arburst == 2'b00;
        aw_slverr = s_axi_awburst[1];
        ar_slverr = s_axi_arburst[1];
        aw_mask   = '1;
        ar_mask   = '1;
`ifdef AXI4_SRAM_WRAP_BURST_EN
        if (s_axi_awburst == 2'b10 && wrap_len_ok(s_axi_awlen)) begin
            aw_slverr = 1'b0;
            aw_mask   = (ADDR_WIDTH'(s_axi_awlen) << SHIFT) | ADDR_WIDTH'(BYTES - 1);
        end
        if (s_axi_arburst == 2'b10 && wrap_len_ok(s_axi_arlen)) begin
            ar_slverr = 1'b0;
            ar_mask   = (ADDR_WIDTH'(s_axi_arlen) << SHIFT) | ADDR_WIDTH'(BYTES - 1);
        end
`endif
    end

    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_mask;
    logic [7:0]            w_len, w_cnt;
    logic                  w_fixed, w_slverr, w_decerr;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, w_ok;

    assign s_axi_awready = (w_state == W_IDLE) && !areset;
    assign s_axi_wready  = (w_state == W_DATA) && !areset;
    assign s_axi_bvalid  = (w_state == W_RESP) && !areset;
    assign s_axi_bid     = areset ? '0 : w_id;
    assign s_axi_bresp   = areset ? RESP_OKAY : w_decerr ? RESP_DECERR :
                           w_slverr ? RESP_SLVERR : RESP_OKAY;
    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign b_hs        = s_axi_bvalid && s_axi_bready;
    assign w_last_beat = w_cnt == w_len;
    assign w_ok        = in_range(w_addr);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state  <= W_IDLE;
            w_id     <= '0;
            w_addr   <= '0;
            w_mask   <= '1;
            w_len    <= '0;
            w_cnt    <= '0;
            w_fixed  <= 1'b0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id     <= s_axi_awid;
                w_addr   <= s_axi_awaddr;
                w_mask   <= aw_mask;
                w_len    <= s_axi_awlen;
                w_cnt    <= '0;
                w_fixed  <= aw_fixed;
                w_slverr <= aw_slverr;
                w_decerr <= 1'b0;
            end
            if (w_hs) begin
                if (!w_ok) w_decerr <= 1'b1;
                if (s_axi_wlast != w_last_beat) w_slverr <= 1'b1;
                w_cnt  <= w_cnt + 8'd1;
                w_addr <= next_addr(w_addr, w_fixed, w_mask);
            end
        end
    end

    // Contents survive reset; a read loading on the same edge sees the old word.
    always_ff @(posedge aclk) begin
        if (w_hs && w_ok)
            for (int b = 0; b < BYTES; b++)
                if (s_axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end

    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_mask, ld_addr;
    logic [7:0]            r_len, r_cnt, ld_cnt, ld_len;
    logic [3:0]            r_wait;
    logic                  r_fixed, r_slverr, ld_en, ld_slverr, ar_hs, r_hs;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;

    assign s_axi_arready = (r_state == R_IDLE) && !areset;
    assign s_axi_rvalid  = (r_state == R_DATA) && !areset;
    assign s_axi_rlast   = s_axi_rvalid && rlast_q;
    assign s_axi_rid     = areset ? '0 : r_id;
    assign s_axi_rdata   = areset ? '0 : rdata_q;
    assign s_axi_rresp   = areset ? RESP_OKAY : rresp_q;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    // ld_* selects which beat gets captured into the R output registers this edge
    always_comb begin
        r_next    = r_state;
        ld_en     = 1'b0;
        ld_addr   = r_addr;
        ld_cnt    = r_cnt;
        ld_len    = r_len;
        ld_slverr = r_slverr;
        case (r_state)
            R_IDLE: if (ar_hs) begin
                if (RD_LATENCY == 0) begin
                    r_next    = R_DATA;
                    ld_en     = 1'b1;
                    ld_addr   = s_axi_araddr;
                    ld_cnt    = '0;
                    ld_len    = s_axi_arlen;
                    ld_slverr = ar_slverr;
                end else begin
                    r_next = R_WAIT;
                end
            end
            R_WAIT: if (r_wait == '0) begin
                r_next = R_DATA;
                ld_en  = 1'b1;
            end
            R_DATA: if (r_hs) begin
                if (rlast_q) begin
                    r_next = R_IDLE;
                end else begin
                    ld_en   = 1'b1;
                    ld_addr = next_addr(r_addr, r_fixed, r_mask);
                    ld_cnt  = r_cnt + 8'd1;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state  <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_mask   <= '1;
            r_len    <= '0;
            r_cnt    <= '0;
            r_fixed  <= 1'b0;
            r_slverr <= 1'b0;
            r_wait   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id     <= s_axi_arid;
                r_addr   <= s_axi_araddr;
                r_mask   <= ar_mask;
                r_len    <= s_axi_arlen;
                r_cnt    <= '0;
                r_fixed  <= ar_fixed;
                r_slverr <= ar_slverr;
                r_wait   <= 4'(RD_LATENCY - 1);
            end else if (r_state == R_WAIT) begin
                r_wait <= r_wait - 4'd1;
            end
            if (ld_en) begin
                r_addr  <= ld_addr;
                r_cnt   <= ld_cnt;
                rdata_q <= in_range(ld_addr) ? mem[word_idx(ld_addr)] : '0;
                rresp_q <= !in_range(ld_addr) ? RESP_DECERR :
                           ld_slverr ? RESP_SLVERR : RESP_OKAY;
                rlast_q <= ld_cnt == ld_len;
            end
        end
    end
endmodule
